pixel_pack_writer: RTL and testbench

PIXEL_PACK_WRITER -- requirements
Module: pixel_pack_writer

---
 rtl/dsa_pkg.sv | 15 +
 rtl/pack_word_fifo.sv | 60 ++++++
 rtl/pixel_pack_writer.sv | 153 +++++++++++++++
 tb/tb_pixel_pack_writer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/dsa_pkg.sv
// Shared types for the pixel packing path.
// word_entry_t is one packed memory word as it sits in the word FIFO:
//   addr - word address (byte address >> 2)
//   data - four pixels, lane k at bits [8k+7:8k]
//   strb - byte enables, bit k = lane k
package dsa_pkg;
   localparam int PIX_W      = 8;
   localparam int WORD_BYTES = 4;

   typedef struct packed {
      logic [29:0]                 addr;
      logic [PIX_W*WORD_BYTES-1:0] data;
      logic [WORD_BYTES-1:0]       strb;
   } word_entry_t;
endpackage

// File: rtl/pack_word_fifo.sv
// Synchronous word FIFO with a registered head.
// Ports:
//   clk, rst_n     - clock, async active-low reset
//   clear_i        - synchronous flush of all entries
//   push_i         - write push_entry_i (dropped when full and not popping)
//   pop_i          - consume the head entry
//   head_o         - head entry, zero when empty
//   valid_o        - FIFO non-empty
//   drop_o         - a push was discarded this cycle
module pack_word_fifo
   import dsa_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clear_i,
   input  logic        push_i,
   input  word_entry_t push_entry_i,
   input  logic        pop_i,
   output word_entry_t head_o,
   output logic        valid_o,
   output logic        drop_o
);
   localparam int AW = $clog2(DEPTH);

   // One extra pointer bit distinguishes full from empty.
   logic [AW:0] wr_ptr_q, rd_ptr_q;
   word_entry_t mem_q [DEPTH];
   logic        empty, full, do_push, do_pop;

   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign do_pop  = pop_i && !empty && !clear_i;
   // When full, a same-cycle pop frees the slot the write lands in.
   assign do_push = push_i && !clear_i && (!full || do_pop);
   assign drop_o  = push_i && !clear_i && full && !do_pop;

   assign valid_o = !empty;
   assign head_o  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else if (clear_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   // Storage needs no reset: it is only visible through head_o while non-empty.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_entry_i;
   end
endmodule

// File: rtl/pixel_pack_writer.sv
// Packs byte-wide pixel writes into 32-bit masked memory words.
// Ports:
//   clk, rst_n                   - clock, async active-low reset
//   clear                        - sync pulse: drop all state, zero counter/flags
//   pix_valid/pix_addr/pix_data  - byte write stream (no backpressure)
//   flush                        - end of frame: drain partial word
//   mem_valid/mem_ready          - word handshake to memory
//   mem_addr/mem_data/mem_strb   - word-aligned address, packed data, byte enables
//   busy                         - work outstanding
//   flush_done                   - one-cycle pulse once a flushed frame has drained
//   overflow                     - sticky, a word was lost on a full FIFO
//   words_out                    - words handed to memory since clear
module pixel_pack_writer
   import dsa_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             pix_valid,
   input  logic [31:0]      pix_addr,
   input  logic [7:0]       pix_data,
   input  logic             flush,
   output logic             mem_valid,
   input  logic             mem_ready,
   output logic [31:0]      mem_addr,
   output logic [31:0]      mem_data,
   output logic [3:0]       mem_strb,
   output logic             busy,
   output logic             flush_done,
   output logic             overflow,
   output logic [CNT_W-1:0] words_out
);
   logic [29:0]      acc_addr_q, acc_addr_d;
   logic [31:0]      acc_data_q, acc_data_d;
   logic [3:0]       acc_strb_q, acc_strb_d;
   logic             flush_pend_q, flush_pend_d;
   logic             overflow_q, overflow_d;
   logic [CNT_W-1:0] words_q, words_d;

   logic        push, pop, fifo_drop, acc_empty, done_c;
   word_entry_t push_entry, head;
   logic [1:0]  lane;
   logic [29:0] pix_word;
   logic [31:0] m_data;
   logic [3:0]  m_strb;

   assign lane      = pix_addr[1:0];
   assign pix_word  = pix_addr[31:2];
   assign acc_empty = (acc_strb_q == 4'h0);
   assign pop       = mem_valid && mem_ready && !clear;
   assign done_c    = flush_pend_q && acc_empty && !mem_valid;

   always_comb begin
      acc_addr_d   = acc_addr_q;
      acc_data_d   = acc_data_q;
      acc_strb_d   = acc_strb_q;
      flush_pend_d = flush_pend_q;
      overflow_d   = overflow_q | fifo_drop;
      words_d      = pop ? words_q + CNT_W'(1) : words_q;
      push         = 1'b0;
      push_entry   = '0;
      m_data       = acc_data_q;
      m_strb       = acc_strb_q | (4'b0001 << lane);
      m_data[{lane, 3'b000} +: 8] = pix_data;

      if (pix_valid) begin
         if (acc_empty || pix_word == acc_addr_q) begin
            if (m_strb == 4'hF) begin
               // Completed word goes straight out; accumulator left empty.
               push       = 1'b1;
               push_entry = '{addr: pix_word, data: m_data, strb: m_strb};
               acc_data_d = '0;
               acc_strb_d = 4'h0;
            end else begin
               acc_addr_d = pix_word;
               acc_data_d = m_data;
               acc_strb_d = m_strb;
            end
         end else begin
            // Word change: evict the partial word, restart with this byte.
            push       = 1'b1;
            push_entry = '{addr: acc_addr_q, data: acc_data_q, strb: acc_strb_q};
            acc_addr_d = pix_word;
            acc_data_d = '0;
            acc_data_d[{lane, 3'b000} +: 8] = pix_data;
            acc_strb_d = 4'b0001 << lane;
         end
      end

      // Flush drains whatever remains after this cycle's byte has merged,
      // but only on a cycle the packing path left the push slot free.
      if ((flush_pend_q || flush) && !push && acc_strb_d != 4'h0) begin
         push       = 1'b1;
         push_entry = '{addr: acc_addr_d, data: acc_data_d, strb: acc_strb_d};
         acc_data_d = '0;
         acc_strb_d = 4'h0;
      end

      if (flush)       flush_pend_d = 1'b1;
      else if (done_c) flush_pend_d = 1'b0;

      if (clear) begin
         acc_addr_d   = '0;
         acc_data_d   = '0;
         acc_strb_d   = '0;
         flush_pend_d = 1'b0;
         overflow_d   = 1'b0;
         words_d      = '0;
         push         = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_addr_q   <= '0;
         acc_data_q   <= '0;
         acc_strb_q   <= '0;
         flush_pend_q <= 1'b0;
         overflow_q   <= 1'b0;
         words_q      <= '0;
      end else begin
         acc_addr_q   <= acc_addr_d;
         acc_data_q   <= acc_data_d;
         acc_strb_q   <= acc_strb_d;
         flush_pend_q <= flush_pend_d;
         overflow_q   <= overflow_d;
         words_q      <= words_d;
      end
   end

   pack_word_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk          (clk),
      .rst_n        (rst_n),
      .clear_i      (clear),
      .push_i       (push),
      .push_entry_i (push_entry),
      .pop_i        (pop),
      .head_o       (head),
      .valid_o      (mem_valid),
      .drop_o       (fifo_drop)
   );

   assign mem_addr   = {head.addr, 2'b00};
   assign mem_data   = head.data;
   assign mem_strb   = head.strb;
   assign busy       = !acc_empty || mem_valid || flush_pend_q;
   assign flush_done = done_c && !clear;
   assign overflow   = overflow_q;
   assign words_out  = words_q;
endmodule

// File: tb/tb_pixel_pack_writer.sv
module tb_pixel_pack_writer;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clear = 1'b0;
   logic        pix_valid = 1'b0;
   logic [31:0] pix_addr = '0;
   logic [7:0]  pix_data = '0;
   logic        flush = 1'b0;
   logic        mem_ready = 1'b0;
   logic        mem_valid;
   logic [31:0] mem_addr, mem_data;
   logic [3:0]  mem_strb;
   logic        busy, flush_done, overflow;
   logic [15:0] words_out;

   pixel_pack_writer #(.FIFO_DEPTH(4), .CNT_W(16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (clear),
      .pix_valid  (pix_valid),
      .pix_addr   (pix_addr),
      .pix_data   (pix_data),
      .flush      (flush),
      .mem_valid  (mem_valid),
      .mem_ready  (mem_ready),
      .mem_addr   (mem_addr),
      .mem_data   (mem_data),
      .mem_strb   (mem_strb),
      .busy       (busy),
      .flush_done (flush_done),
      .overflow   (overflow),
      .words_out  (words_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        pv;
      logic [31:0] addr;
      logic [7:0]  data;
      logic        fl;
      logic        push;
      logic [31:0] e_addr;
      logic [31:0] e_data;
      logic [3:0]  e_strb;
   } vec_t;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
   } exp_t;

   vec_t vt[$];
   exp_t exp_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   failures = 0;
   int   fd_cnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic void add(input logic pv, input logic [31:0] a, input logic [7:0] d,
                               input logic fl, input logic p, input logic [31:0] ea,
                               input logic [31:0] ed, input logic [3:0] es);
      vec_t v;
      v.pv = pv; v.addr = a; v.data = d; v.fl = fl;
      v.push = p; v.e_addr = ea; v.e_data = ed; v.e_strb = es;
      vt.push_back(v);
   endfunction

   function automatic void expect_word(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      exp_t e;
      e.addr = a; e.data = d; e.strb = s;
      exp_q.push_back(e);
   endfunction

   // Scoreboard: every accepted handshake must match the oldest expected word.
   always @(negedge clk) begin
      if (rst_n && flush_done) fd_cnt++;
      if (rst_n && !clear && mem_valid && mem_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_word: got addr %0h data %0h strb %0h, none expected",
                     mem_addr, mem_data, mem_strb);
         end else begin
            mon_e = exp_q.pop_front();
            chk("word_addr", mem_addr, mon_e.addr);
            chk("word_data", mem_data, mon_e.data);
            chk("word_strb", {28'h0, mem_strb}, {28'h0, mon_e.strb});
         end
      end
   end

   task automatic cyc(input logic pv, input logic [31:0] a, input logic [7:0] d, input logic fl);
      pix_valid = pv; pix_addr = a; pix_data = d; flush = fl;
      @(posedge clk); #1;
      pix_valid = 1'b0; flush = 1'b0;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
   endtask

   task automatic drain(input int budget, input string name);
      int n = 0;
      while ((exp_q.size() != 0 || mem_valid) && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (exp_q.size() != 0 || mem_valid) begin
         failures++;
         $display("FAIL %s: drain timeout, got %0d words outstanding expected 0", name, exp_q.size());
      end
   endtask

   task automatic chk_zero_outputs(input string tag);
      chk({tag, "_mem_valid"}, {31'h0, mem_valid}, 32'h0);
      chk({tag, "_mem_addr"}, mem_addr, 32'h0);
      chk({tag, "_mem_data"}, mem_data, 32'h0);
      chk({tag, "_mem_strb"}, {28'h0, mem_strb}, 32'h0);
      chk({tag, "_busy"}, {31'h0, busy}, 32'h0);
      chk({tag, "_flush_done"}, {31'h0, flush_done}, 32'h0);
      chk({tag, "_overflow"}, {31'h0, overflow}, 32'h0);
      chk({tag, "_words_out"}, {16'h0, words_out}, 32'h0);
   endtask

   initial begin
      int seen;
      logic [7:0] b;

      repeat (3) @(posedge clk);
      #1;
      chk_zero_outputs("reset");
      rst_n = 1'b1;
      mem_ready = 1'b1;
      @(posedge clk); #1;

      // Full word of four lanes.
      add(1, 32'h0, 8'd0,   0, 0, 0, 0, 0);
      add(1, 32'h1, 8'd20,  0, 0, 0, 0, 0);
      add(1, 32'h2, 8'd80,  0, 0, 0, 0, 0);
      add(1, 32'h3, 8'd100, 0, 1, 32'h0, 32'h64501400, 4'hF);
      // Partial word drained by flush, then idle for flush_done.
      add(1, 32'h4, 8'h11, 0, 0, 0, 0, 0);
      add(1, 32'h5, 8'h22, 0, 0, 0, 0, 0);
      add(0, 32'h0, 8'h00, 1, 1, 32'h4, 32'h00002211, 4'h3);
      add(0, 32'h0, 8'h00, 0, 0, 0, 0, 0);
      add(0, 32'h0, 8'h00, 0, 0, 0, 0, 0);
      add(0, 32'h0, 8'h00, 0, 0, 0, 0, 0);
      // Word change evicts the partial word; addr 8 stays and later merges with 9.
      add(1, 32'h0, 8'hAA, 0, 0, 0, 0, 0);
      add(1, 32'h8, 8'hBB, 0, 1, 32'h0, 32'h000000AA, 4'h1);
      add(1, 32'h9, 8'hCC, 1, 1, 32'h8, 32'h0000CCBB, 4'h3);
      add(0, 32'h0, 8'h00, 0, 0, 0, 0, 0);
      add(0, 32'h0, 8'h00, 0, 0, 0, 0, 0);
      add(0, 32'h0, 8'h00, 0, 0, 0, 0, 0);
      // Lane 2 rewritten: latest data wins.
      add(1, 32'h12, 8'h33, 0, 0, 0, 0, 0);
      add(1, 32'h12, 8'h44, 0, 0, 0, 0, 0);
      add(1, 32'h10, 8'h01, 0, 0, 0, 0, 0);
      add(1, 32'h11, 8'h02, 0, 0, 0, 0, 0);
      add(1, 32'h13, 8'h04, 0, 1, 32'h10, 32'h04440201, 4'hF);

      for (int i = 0; i < vt.size(); i++) begin
         if (vt[i].push) expect_word(vt[i].e_addr, vt[i].e_data, vt[i].e_strb);
         cyc(vt[i].pv, vt[i].addr, vt[i].data, vt[i].fl);
      end
      drain(50, "table_drain");
      repeat (2) @(posedge clk);
      #1;
      chk("table_words_out", {16'h0, words_out}, 32'd5);
      chk("table_flush_done_pulses", fd_cnt, 32'd2);
      chk("table_overflow", {31'h0, overflow}, 32'h0);
      chk("table_busy", {31'h0, busy}, 32'h0);

      // Backpressure: 20 full words, only the first 4 fit.
      do_clear();
      chk("clear_words_out", {16'h0, words_out}, 32'h0);
      mem_ready = 1'b0;
      for (int w = 0; w < 20; w++) begin
         for (int l = 0; l < 4; l++) begin
            b = 8'(w * 4 + l);
            if (l == 3 && w < 4)
               expect_word(32'(w * 4), {8'(w*4+3), 8'(w*4+2), 8'(w*4+1), 8'(w*4)}, 4'hF);
            cyc(1, 32'(w * 4 + l), b, 0);
         end
      end
      chk("ovf_overflow", {31'h0, overflow}, 32'h1);
      chk("ovf_mem_valid", {31'h0, mem_valid}, 32'h1);
      chk("ovf_head_stable", mem_addr, 32'h0);
      chk("ovf_busy", {31'h0, busy}, 32'h1);
      mem_ready = 1'b1;
      drain(30, "ovf_drain");
      chk("ovf_words_out", {16'h0, words_out}, 32'd4);
      chk("ovf_busy_after", {31'h0, busy}, 32'h0);

      // Reset mid-frame: queued and partial data are discarded.
      do_clear();
      chk("clear_overflow", {31'h0, overflow}, 32'h0);
      mem_ready = 1'b0;
      for (int k = 0; k < 8; k++) cyc(1, 32'(32'h40 + k), 8'(k + 1), 0);
      cyc(1, 32'h48, 8'h5A, 0);
      #2;
      rst_n = 1'b0;
      #1;
      chk_zero_outputs("midreset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      mem_ready = 1'b1;
      seen = 0;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         if (mem_valid) seen++;
      end
      chk("midreset_no_words", seen, 32'h0);
      chk("midreset_words_out", {16'h0, words_out}, 32'h0);
      chk("midreset_busy", {31'h0, busy}, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
